// File: rtl/mod2011_residue_accumulator.sv
// Purpose : sums a stream of 11-bit weighted residue terms modulo MOD and
//           presents the operand's final residue on a held output handshake.
// Latency : out_valid rises the cycle after the term flagged last is accepted.
// Backpr. : in_ready drops while a result is held; DONE persists until out_ready.
//
// Ports
//   clk, rst     rising-edge clock, synchronous active-high reset
//   in_valid     residue term present          in_ready   term accepted this cycle
//   in_term      W-bit residue term            in_last    final slice of operand
//   out_valid    final residue available       out_ready  consumer takes result
//   out_residue  operand value mod MOD         out_count  terms summed (saturating)
//   err          sticky out-of-range term flag
//
// Optional feature: define MOD2011_RANGE_CHECK_EN to pre-reduce terms >= MOD
// and raise the sticky err flag; without it err is tied low.

module mod2011_residue_accumulator #(
  parameter int unsigned MOD = 2011,
  parameter int unsigned W   = 11,
  parameter int unsigned CW  = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_term,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_residue,
  output logic [CW-1:0] out_count,
  output logic          err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [W-1:0] MOD_W  = MOD[W-1:0];
  localparam logic [W:0]   MOD_W1 = MOD[W:0];
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  state_t        state;
  state_t        state_nxt;

  logic [W-1:0]  acc;
  logic [CW-1:0] cnt;

  logic          accept;
  logic [W-1:0]  term_red;
  logic [W-1:0]  base;
  logic [W:0]    sum;
  logic          sum_ge;
  logic [W-1:0]  add_res;
  logic [CW-1:0] cnt_base;
  logic [CW-1:0] cnt_nxt;

  // ---------------------------------------------------------------------------
  // Term conditioning
  // ---------------------------------------------------------------------------
`ifdef MOD2011_RANGE_CHECK_EN
  logic term_oor;
  logic err_q;

  // Any W-bit value is below 2*MOD, so a single subtract brings it in range.
  assign term_oor = (in_term >= MOD_W);
  assign term_red = term_oor ? (in_term - MOD_W) : in_term;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (accept && term_oor) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign term_red = in_term;
  assign err      = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Modular add: both operands are < MOD, so one conditional subtract reduces
  // the (W+1)-bit sum. When the subtract applies the result is < MOD < 2^W,
  // so it can be done at W bits and the wrap discards the carry.
  // ---------------------------------------------------------------------------
  assign accept   = in_valid && in_ready;
  assign base     = (state == ACC) ? acc : '0;
  assign sum      = {1'b0, base} + {1'b0, term_red};
  assign sum_ge   = (sum >= MOD_W1);
  assign add_res  = sum_ge ? (sum[W-1:0] - MOD_W) : sum[W-1:0];

  // Term count restarts from zero on the first term of an operand.
  assign cnt_base = (state == ACC) ? cnt : '0;
  assign cnt_nxt  = (cnt_base == CNT_MAX) ? cnt_base : (cnt_base + CW'(1));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, ACC: begin
        if (accept) begin
          state_nxt = in_last ? DONE : ACC;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output decode. Both are pure decodes of the state register, so there
  // is no combinational path from in_valid or out_ready to either handshake.
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    case (state)
      DONE: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
      end
      default: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers. The result registers keep their value after the
  // handshake; only out_valid qualifies them.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      acc         <= '0;
      cnt         <= '0;
      out_residue <= '0;
      out_count   <= '0;
    end else begin
      case (state)
        IDLE, ACC: begin
          if (accept) begin
            if (in_last) begin
              out_residue <= add_res;
              out_count   <= cnt_nxt;
            end else begin
              acc <= add_res;
              cnt <= cnt_nxt;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            acc <= '0;
            cnt <= '0;
          end
        end
        default: begin
          acc <= '0;
          cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mod2011_residue_accumulator.sv
module tb_mod2011_residue_accumulator;

  localparam int MOD  = 2011;
  localparam int W    = 11;
  localparam int CW   = 6;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_term;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_residue;
  logic [CW-1:0] out_count;
  logic          err;

  int n_checks = 0;
  int n_errors = 0;

  int ops[$];
  bit bubbles;
  bit exp_err;

  always #5 clk = ~clk;

  mod2011_residue_accumulator #(.MOD(MOD), .W(W), .CW(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_term     (in_term),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_residue (out_residue),
    .out_count   (out_count),
    .err         (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Sends the terms in ops[] as one operand, then checks the held result and
  // the handshake. The reference is plain integer arithmetic over the terms.
  task automatic run_op(input string tag, input int hold);
    int n;
    int sum;
    int exp_res;
    int exp_cnt;
    int h;
    n   = ops.size();
    sum = 0;
    for (int i = 0; i < n; i++) begin
      if (bubbles) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0;
          in_term  = W'($urandom);
          in_last  = 1'($urandom);
          @(negedge clk);
        end
      end
      check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_term  = W'(ops[i]);
      in_last  = (i == n - 1);
      @(negedge clk);
      sum += ops[i];
`ifdef MOD2011_RANGE_CHECK_EN
      if (ops[i] >= MOD) exp_err = 1'b1;
`endif
    end
    in_valid = 1'b0;
    exp_res  = sum % MOD;
    exp_cnt  = (n > CMAX) ? CMAX : n;

    check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_busy"}, 32'(in_ready), 32'd0);
    check({tag, "_residue"}, 32'(out_residue), 32'(exp_res));
    check({tag, "_count"}, 32'(out_count), 32'(exp_cnt));
    check({tag, "_err"}, 32'(err), 32'(exp_err));

    // Back-pressure: garbage on the input side must be ignored while held.
    h = (hold < 0) ? int'($urandom_range(0, 4)) : hold;
    repeat (h) begin
      in_valid = 1'b1;
      in_term  = W'($urandom);
      in_last  = 1'($urandom);
      @(negedge clk);
      check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_hold_residue"}, 32'(out_residue), 32'(exp_res));
      check({tag, "_hold_count"}, 32'(out_count), 32'(exp_cnt));
      check({tag, "_hold_busy"}, 32'(in_ready), 32'd0);
    end

    in_valid  = 1'b1;
    in_term   = W'($urandom);
    in_last   = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check({tag, "_released"}, 32'(out_valid), 32'd0);
    check({tag, "_ready_again"}, 32'(in_ready), 32'd1);
    check({tag, "_residue_kept"}, 32'(out_residue), 32'(exp_res));
    check({tag, "_count_kept"}, 32'(out_count), 32'(exp_cnt));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_residue"}, 32'(out_residue), 32'd0);
    check({tag, "_count"}, 32'(out_count), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_term   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    bubbles   = 1'b0;
    exp_err   = 1'b0;

    repeat (2) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;
    @(negedge clk);

    // Directed cases
    ops = '{1234};
    run_op("single", 0);
    ops = '{2010, 2010, 5};
    run_op("worst_add", -1);
    ops = '{1000, 1011};
    run_op("exact_wrap", 5);

    bubbles = 1'b1;
    ops.delete();
    repeat (70) ops.push_back(1);
    run_op("saturate", 1);

    // Reset after 3 of 5 terms: the partial sum must be discarded.
    bubbles = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_term  = W'(100 * (i + 1));
      in_last  = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_state("mid_reset");
    ops = '{7};
    run_op("after_reset", 0);

`ifdef MOD2011_RANGE_CHECK_EN
    ops = '{2047};
    run_op("range", 0);
    ops = '{5, 6};
    run_op("range_sticky", 0);
    rst = 1'b1;
    @(negedge clk);
    rst     = 1'b0;
    exp_err = 1'b0;
    check_reset_state("range_clear");
`endif

    // Randomized operands
    for (int k = 0; k < 30; k++) begin
      int n;
      bubbles = 1'($urandom);
      n = $urandom_range(1, 80);
      ops.delete();
      for (int i = 0; i < n; i++) begin
`ifdef MOD2011_RANGE_CHECK_EN
        if ($urandom_range(0, 9) == 0) ops.push_back($urandom_range(MOD, (1 << W) - 1));
        else ops.push_back($urandom_range(0, MOD - 1));
`else
        ops.push_back($urandom_range(0, MOD - 1));
`endif
      end
      run_op("random", -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
